// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: bus-master sequencer for the FIR register slave.
// Loads num_taps coefficients, switches the filter to run mode, then for each
// sample writes x, waits out the filter latency, reads the result and hands it
// to a valid/ready output stream.
module fir_seq_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_W      = 16,
    parameter int FIR_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [CNT_W-1:0]      num_taps,
    input  logic [CNT_W-1:0]      num_samples,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] coef_data,
    input  logic                  coef_valid,
    output logic                  coef_ready,
    input  logic [DATA_WIDTH-1:0] samp_data,
    input  logic                  samp_valid,
    output logic                  samp_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  m_cs,
    output logic                  m_write,
    output logic                  m_read,
    output logic [1:0]            m_addr,
    output logic [DATA_WIDTH-1:0] m_write_data,
    input  logic [DATA_WIDTH-1:0] m_read_data
);

    // Slave register map
    localparam logic [1:0] ADDR_B    = 2'd0;
    localparam logic [1:0] ADDR_X    = 2'd1;
    localparam logic [1:0] ADDR_CTRL = 2'd2;

    localparam logic [3:0] LAT = 4'(FIR_LAT);

    typedef enum logic [3:0] {
        IDLE,
        SET_LOAD,
        COEF,
        SET_RUN,
        SAMP_WR,
        SAMP_WAIT,
        SAMP_RD,
        SAMP_CAP,
        OUT,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] taps_q;
    logic [CNT_W-1:0] samps_q;
    logic [CNT_W-1:0] tap_cnt;
    logic [CNT_W-1:0] samp_cnt;
    logic [CNT_W-1:0] tap_nxt;
    logic [CNT_W-1:0] samp_nxt;
    logic [3:0]       wait_cnt;

    // Counters compare by equality after the increment, so the full
    // 2^CNT_W-1 range works without an extra counter bit.
    assign tap_nxt  = tap_cnt + 1'b1;
    assign samp_nxt = samp_cnt + 1'b1;

    // Stream readies depend only on the state, so they cannot combinationally
    // loop back through the upstream valid.
    assign coef_ready = (state == COEF);
    assign samp_ready = (state == SAMP_WR);

    // Sequencer: state, counters and every registered output.
    // A bus access is issued one cycle after the state that decides it, except
    // the result read, which is launched as SAMP_WAIT ends so that the read
    // data arrives exactly in SAMP_CAP.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge only; every register,
        // outputs included, is cleared here so the block restarts from IDLE
        // with a quiet bus even when reset lands mid-transaction.
        if (!reset_n) begin
            state        <= IDLE;
            taps_q       <= '0;
            samps_q      <= '0;
            tap_cnt      <= '0;
            samp_cnt     <= '0;
            wait_cnt     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            res_data     <= '0;
            res_valid    <= 1'b0;
            m_cs         <= 1'b0;
            m_write      <= 1'b0;
            m_read       <= 1'b0;
            m_addr       <= '0;
            m_write_data <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; these defaults make
            // every strobe a single-cycle pulse unless a state below re-asserts it.
            m_cs    <= 1'b0;
            m_write <= 1'b0;
            m_read  <= 1'b0;
            done    <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        taps_q   <= num_taps;
                        samps_q  <= num_samples;
                        tap_cnt  <= '0;
                        samp_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= SET_LOAD;
                    end
                end

                SET_LOAD: begin
                    m_cs         <= 1'b1;
                    m_write      <= 1'b1;
                    m_addr       <= ADDR_CTRL;
                    m_write_data <= DATA_WIDTH'(1);
                    state        <= (taps_q != '0) ? COEF : SET_RUN;
                end

                COEF: begin
                    if (coef_valid) begin
                        m_cs         <= 1'b1;
                        m_write      <= 1'b1;
                        m_addr       <= ADDR_B;
                        m_write_data <= coef_data;
                        tap_cnt      <= tap_nxt;
                        if (tap_nxt == taps_q) begin
                            state <= SET_RUN;
                        end
                    end
                end

                SET_RUN: begin
                    m_cs         <= 1'b1;
                    m_write      <= 1'b1;
                    m_addr       <= ADDR_CTRL;
                    m_write_data <= '0;
                    if (samps_q != '0) begin
                        state <= SAMP_WR;
                    end else begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                SAMP_WR: begin
                    if (samp_valid) begin
                        m_cs         <= 1'b1;
                        m_write      <= 1'b1;
                        m_addr       <= ADDR_X;
                        m_write_data <= samp_data;
                        wait_cnt     <= '0;
                        state        <= SAMP_WAIT;
                    end
                end

                // The x write occupies the first SAMP_WAIT cycle; the read is
                // launched after FIR_LAT further cycles, leaving exactly
                // FIR_LAT idle bus cycles in between.
                SAMP_WAIT: begin
                    if (wait_cnt == LAT) begin
                        m_cs   <= 1'b1;
                        m_read <= 1'b1;
                        m_addr <= ADDR_X;
                        state  <= SAMP_RD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                SAMP_RD: begin
                    state <= SAMP_CAP;
                end

                SAMP_CAP: begin
                    res_data  <= m_read_data;
                    res_valid <= 1'b1;
                    state     <= OUT;
                end

                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        samp_cnt  <= samp_nxt;
                        if (samp_nxt == samps_q) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= SAMP_WR;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
